universal_shift_register: RTL

//   Parametrised N-bit register with a 3-bit mode select: hold, parallel load,

---
 rtl/usr_pkg.sv | 28 ++
 rtl/usr_shift_counter.sv | 35 +++
 rtl/universal_shift_register.sv | 69 ++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Mode encodings and helpers for universal_shift_register.
// USR_ARITH_SHIFT_EN turns mode 110 into an arithmetic right shift.
package usr_pkg;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_LOAD = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_SHR  = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_ROR  = 3'b101;
   localparam logic [2:0] MODE_ASR  = 3'b110;
   localparam logic [2:0] MODE_CLR  = 3'b111;

   function automatic logic is_shift_mode(input logic [2:0] m);
      logic r;
      r = (m == MODE_SHL) || (m == MODE_SHR) ||
          (m == MODE_ROL) || (m == MODE_ROR);
`ifdef USR_ARITH_SHIFT_EN
      r = r || (m == MODE_ASR);
`endif
      return r;
   endfunction

   function automatic logic is_clear_mode(input logic [2:0] m);
      return (m == MODE_LOAD) || (m == MODE_CLR);
   endfunction

endpackage

// File: rtl/usr_shift_counter.sv
// Saturating count of shift/rotate ops since the last load/clear.
// o_done is a level that stays high while the count sits at N.
module usr_shift_counter
   import usr_pkg::*;
#(
   parameter int  N  = 4,
   localparam int CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_clear,
   input  logic          i_inc,
   output logic [CW-1:0] o_cnt,
   output logic          o_done
);

   logic [CW-1:0] r_cnt;
   logic          w_sat;

   assign w_sat = (r_cnt == CW'(N));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_inc && !w_sat) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt  = r_cnt;
   assign o_done = w_sat;

endmodule

// File: rtl/universal_shift_register.sv
// N-bit register with hold/load/shift/rotate/clear and a serializer count.
// Define USR_ARITH_SHIFT_EN to make mode 110 an arithmetic right shift.
module universal_shift_register
   import usr_pkg::*;
#(
   parameter int  N  = 4,
   localparam int CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [2:0]    mode,
   input  logic [N-1:0]  D,
   input  logic          sin_l,
   input  logic          sin_r,
   output logic [N-1:0]  Q,
   output logic          sout_l,
   output logic          sout_r,
   output logic [CW-1:0] cnt,
   output logic          shift_done
);

   logic [N-1:0] r_q;
   logic [N-1:0] w_q_nxt;
   logic         w_clear;
   logic         w_inc;

   always_comb begin
      w_q_nxt = r_q;
      unique case (mode)
         MODE_HOLD: w_q_nxt = r_q;
         MODE_LOAD: w_q_nxt = D;
         MODE_SHL:  w_q_nxt = {r_q[N-2:0], sin_r};
         MODE_SHR:  w_q_nxt = {sin_l, r_q[N-1:1]};
         MODE_ROL:  w_q_nxt = {r_q[N-2:0], r_q[N-1]};
         MODE_ROR:  w_q_nxt = {r_q[0], r_q[N-1:1]};
`ifdef USR_ARITH_SHIFT_EN
         MODE_ASR:  w_q_nxt = {r_q[N-1], r_q[N-1:1]};
`else
         MODE_ASR:  w_q_nxt = r_q;
`endif
         MODE_CLR:  w_q_nxt = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else begin
         r_q <= w_q_nxt;
      end
   end

   assign w_clear = is_clear_mode(mode);
   assign w_inc   = is_shift_mode(mode);

   usr_shift_counter #(.N(N)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_clear),
      .i_inc   (w_inc),
      .o_cnt   (cnt),
      .o_done  (shift_done)
   );

   assign Q      = r_q;
   assign sout_l = r_q[N-1];
   assign sout_r = r_q[0];

endmodule
